// File: rtl/clock_enable_divider_mc_if.sv
// Bundles the control and status signals of the multi-channel clock-enable divider.
// Clock and reset stay as plain module ports.
interface clock_enable_divider_mc_if #(
  parameter int par_channels  = 4,
  parameter int par_div_width = 16
);
  logic                                  i_ce_mhz;
  logic [par_channels-1:0]               i_run;
  logic [par_channels-1:0]               i_oneshot;
  logic [par_channels-1:0]               i_load;
  logic [par_channels*par_div_width-1:0] i_divisor;
  logic                                  i_sync;
  logic [par_channels-1:0]               o_ce_div;
  logic [par_channels-1:0]               o_busy;

  modport master (
    output i_ce_mhz, i_run, i_oneshot, i_load, i_divisor, i_sync,
    input  o_ce_div, o_busy
  );

  modport slave (
    input  i_ce_mhz, i_run, i_oneshot, i_load, i_divisor, i_sync,
    output o_ce_div, o_busy
  );
endinterface

// File: rtl/clock_enable_divider_mc.sv
// Multi-channel clock-enable divider: each channel counts qualified i_ce_mhz cycles
// and emits a one-clock o_ce_div pulse per divisor period, continuous or one-shot.
module clock_enable_divider_mc #(
  parameter int par_channels        = 4,
  parameter int par_div_width       = 16,
  parameter int par_default_divisor = 1000
) (
  input  logic                      i_clk_mhz,
  input  logic                      i_rst_mhz,
  clock_enable_divider_mc_if.slave  bus
);

  localparam logic [par_div_width-1:0] DIV_ONE = par_div_width'(1);
  localparam logic [par_div_width-1:0] DEF_RAW = par_div_width'(par_default_divisor);
  localparam logic [par_div_width-1:0] DEF_DIV = (DEF_RAW == '0) ? DIV_ONE : DEF_RAW;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  genvar gi;
  generate
    for (gi = 0; gi < par_channels; gi++) begin : g_ch
      state_e                   state_q, state_d;
      logic [par_div_width-1:0] cnt_q, cnt_d;
      logic [par_div_width-1:0] div_q, div_d;
      logic [par_div_width-1:0] div_slice;
      logic                     mode_q, mode_d;
      logic                     pulse_q, pulse_d;

      assign div_slice = bus.i_divisor[gi*par_div_width +: par_div_width];

      always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        mode_d  = mode_q;
        pulse_d = 1'b0;

        // A zero divisor behaves as 1 so the terminal compare never wraps.
        if (bus.i_load[gi]) begin
          div_d = (div_slice == '0) ? DIV_ONE : div_slice;
        end

        unique case (state_q)
          ST_IDLE: begin
            cnt_d = '0;
            if (bus.i_run[gi]) begin
              state_d = ST_RUN;
              mode_d  = bus.i_oneshot[gi];
            end
          end
          ST_RUN: begin
            if (!bus.i_run[gi]) begin
              state_d = ST_IDLE;
              cnt_d   = '0;
            end else if (bus.i_load[gi] || bus.i_sync) begin
              cnt_d = '0;
            end else if (bus.i_ce_mhz) begin
              if (cnt_q == div_q - DIV_ONE) begin
                cnt_d   = '0;
                pulse_d = 1'b1;
                if (mode_q) begin
                  state_d = ST_DONE;
                end
              end else begin
                cnt_d = cnt_q + DIV_ONE;
              end
            end
          end
          ST_DONE: begin
            cnt_d = '0;
            if (!bus.i_run[gi]) begin
              state_d = ST_IDLE;
            end
          end
          default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end
        endcase
      end

      always_ff @(posedge i_clk_mhz) begin
        if (i_rst_mhz) begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
          div_q   <= DEF_DIV;
          mode_q  <= 1'b0;
          pulse_q <= 1'b0;
        end else begin
          state_q <= state_d;
          cnt_q   <= cnt_d;
          div_q   <= div_d;
          mode_q  <= mode_d;
          pulse_q <= pulse_d;
        end
      end

      assign bus.o_ce_div[gi] = pulse_q;
      assign bus.o_busy[gi]   = (state_q == ST_RUN);
    end
  endgenerate

endmodule

// File: doc/clock_enable_divider_mc.md
CLOCK_ENABLE_DIVIDER_MC -- requirements
Module: clock_enable_divider_mc

Interface
REQ-001 SHALL provide parameter par_channels, default 4: number of independent divider channels (1..16).
REQ-002 SHALL provide parameter par_div_width, default 16: width of each channel divisor.
REQ-003 SHALL provide parameter par_default_divisor, default 1000: divisor every channel loads at reset (1..2^par_div_width-1).
REQ-004 SHALL have one clock and a synchronous, active-high reset; all logic is clocked on the rising edge of i_clk_mhz.
REQ-005 i_clk_mhz  in  1  system clock.
REQ-006 i_rst_mhz  in  1  synchronous active-high reset.
REQ-007 i_ce_mhz  in  1  source clock enable; only cycles with i_ce_mhz=1 advance counters.
REQ-008 i_run  in  par_channels  per-channel run level.
REQ-009 i_oneshot  in  par_channels  per-channel mode (1=one-shot, 0=continuous), sampled on IDLE->RUN entry.
REQ-010 i_load  in  par_channels  per-channel divisor load strobe.
REQ-011 i_divisor  in  par_channels*par_div_width  packed divisors; channel n uses bits [n*W +: W].
REQ-012 i_sync  in  1  global phase-align strobe.
REQ-013 o_ce_div  out  par_channels  per-channel divided clock-enable pulse, one i_clk_mhz cycle wide.
REQ-014 o_busy  out  par_channels  per-channel 1 while in RUN.

Function
REQ-015 Each channel SHALL implement states IDLE, RUN, DONE with a counter cnt (par_div_width bits) and a divisor register div.
REQ-016 IDLE: cnt=0; i_run[n]=1 -> RUN next cycle; the i_ce_mhz of the transition cycle is not counted; the mode bit is latched from i_oneshot[n].
REQ-017 RUN: on a cycle with i_ce_mhz=1, if cnt==div-1 then cnt<=0 and o_ce_div[n]=1 in the following cycle, else cnt<=cnt+1.
REQ-018 o_ce_div[n] SHALL be 0 in every cycle except the one following a terminal-count cycle (latency 1 clock, width 1 clock, independent of the i_ce_mhz duty).
REQ-019 Continuous mode SHALL pulse every div qualified i_ce_mhz cycles; the first pulse follows the div-th qualified cycle after entering RUN.
REQ-020 One-shot mode SHALL emit exactly one pulse, then go RUN->DONE on the terminal-count cycle; DONE holds until i_run[n]=0, then returns to IDLE.
REQ-021 i_run[n]=0 in RUN or DONE SHALL go to IDLE next cycle, clear cnt, and suppress any pulse not already registered.
REQ-022 i_load[n]=1 SHALL capture the channel-n slice into div and clear cnt in the same edge, with priority over counting in that cycle; state is unchanged.
REQ-023 A loaded or reset divisor of 0 SHALL be treated as 1; with div=1 every qualified i_ce_mhz cycle in RUN produces a pulse.
REQ-024 i_sync=1 SHALL clear cnt of all channels in the same edge, with priority over counting; a terminal count coinciding with i_sync produces no pulse; div and state are unchanged.
REQ-025 Per-channel priority: i_rst_mhz > i_run low > i_load/i_sync > counting.
REQ-026 Channels SHALL be fully independent apart from the shared i_ce_mhz, i_sync and reset.
REQ-027 o_busy[n]=1 exactly when the channel state is RUN (registered).

Reset
REQ-028 i_rst_mhz=1 SHALL set every channel to IDLE, cnt=0, div=par_default_divisor, o_ce_div=0, o_busy=0 at the next edge, regardless of any other input, including mid-count and in DONE.
REQ-029 After reset release, no pulse SHALL occur until the channel enters RUN and completes div qualified cycles.

Verification
REQ-030 Continuous: div=4, i_ce_mhz=1 constantly, i_run[0] raised -> o_ce_div[0] pulses every 4 clocks, 1 clock wide; first pulse 5 clocks after the i_run edge.
REQ-031 Gated CE: div=3, i_ce_mhz high 1 cycle in 4 -> one pulse per 12 clocks, always one clock after a qualified cycle, never 2 clocks wide.
REQ-032 One-shot: i_oneshot[1]=1, div=5 -> exactly one pulse, o_busy[1] falls on the pulse cycle, no further pulses for 100 clocks; dropping i_run[1] returns the channel to IDLE, and raising it again gives one more pulse.
REQ-033 Load/edge cases: load 0 -> pulse on every qualified cycle; load 7 mid-count -> next pulse exactly 7 qualified cycles after the load.
REQ-034 Sync/abort: channels with div 4 and 6 out of phase, pulse i_sync -> both restart, then pulse together every 12 qualified cycles; i_run low on the terminal-count cycle -> no pulse.
REQ-035 Reset mid-operation: assert i_rst_mhz with cnt=div-1 and i_ce_mhz=1 -> no pulse, all outputs 0, div restored to 1000.
